// File: rtl/mem_pkg.sv
// Shared definitions for the burst memory master.
package mem_pkg;

  // Burst controller states.
  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RD_OUT,
    DONE
  } state_e;

endpackage

// File: rtl/mem_burst_master.sv
// Burst master: turns one command into a sequence of single-word memory
// accesses. Writes stream one beat per accepted wr_valid_i; reads keep a
// single access in flight and present each word until it is consumed.
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_WORDS),
  parameter int unsigned NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [ADDR_WIDTH:0]   cmd_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [NUM_BYTES-1:0]  wr_ben_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  output logic                  mem_w_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_w_data_o,
  output logic [NUM_BYTES-1:0]  mem_b_en_o,
  input  logic [DATA_WIDTH-1:0] mem_r_data_i
);

  localparam int unsigned LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(NUM_WORDS - 1);

  state_e                state;
  state_e                state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [ADDR_WIDTH:0]   remain;
  logic [LAT_W-1:0]      lat_cnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  last_beat;
  logic                  lat_done;

  // Explicit wrap so non-power-of-two depths also stay in range.
  assign addr_next = (addr == ADDR_MAX) ? '0 : addr + 1'b1;
  assign last_beat = (remain == (ADDR_WIDTH + 1)'(1));
  assign lat_done  = (lat_cnt == LAT_LAST);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_len_i == '0)  state_nxt = DONE;
          else if (cmd_write_i) state_nxt = WRITE;
          else                  state_nxt = RD_ISSUE;
        end
      end
      WRITE:    if (wr_valid_i && last_beat) state_nxt = DONE;
      RD_ISSUE: state_nxt = (LATENCY == 0) ? RD_OUT : RD_WAIT;
      RD_WAIT:  if (lat_done) state_nxt = RD_OUT;
      RD_OUT:   if (rd_ready_i) state_nxt = last_beat ? DONE : RD_ISSUE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Burst address, remaining count, latency counter and read data register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr    <= '0;
      remain  <= '0;
      lat_cnt <= '0;
      rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            addr   <= cmd_addr_i;
            remain <= cmd_len_i;
          end
        end
        WRITE: begin
          if (wr_valid_i) begin
            addr   <= addr_next;
            remain <= remain - 1'b1;
          end
        end
        RD_ISSUE: begin
          lat_cnt <= '0;
          if (LATENCY == 0) rd_data <= mem_r_data_i;
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_done) rd_data <= mem_r_data_i;
        end
        RD_OUT: begin
          if (rd_ready_i) begin
            addr   <= addr_next;
            remain <= remain - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode; reset forces the idle-with-ready output pattern.
  always_comb begin
    cmd_ready_o  = 1'b0;
    wr_ready_o   = 1'b0;
    rd_valid_o   = 1'b0;
    rd_data_o    = '0;
    done_o       = 1'b0;
    mem_req_o    = 1'b0;
    mem_w_en_o   = 1'b0;
    mem_addr_o   = '0;
    mem_w_data_o = '0;
    mem_b_en_o   = '0;
    if (rst_i) begin
      cmd_ready_o = 1'b1;
    end else begin
      case (state)
        IDLE: cmd_ready_o = 1'b1;
        WRITE: begin
          wr_ready_o = 1'b1;
          if (wr_valid_i) begin
            mem_req_o    = 1'b1;
            mem_w_en_o   = 1'b1;
            mem_addr_o   = addr;
            mem_w_data_o = wr_data_i;
            mem_b_en_o   = wr_ben_i;
          end
        end
        RD_ISSUE: begin
          mem_req_o  = 1'b1;
          mem_addr_o = addr;
        end
        RD_OUT: begin
          rd_valid_o = 1'b1;
          rd_data_o  = rd_data;
        end
        DONE: done_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a one-cycle-latency memory model
// and scoreboard queues for expected memory requests and read data.
module tb_mem_burst_master;

  localparam int unsigned NW  = 256;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 1;

  logic        clk;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [7:0]  cmd_addr_i;
  logic [8:0]  cmd_len_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_ben_i;
  logic        rd_valid_o;
  logic        rd_ready_i;
  logic [31:0] rd_data_o;
  logic        done_o;
  logic        mem_req_o;
  logic        mem_w_en_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_w_data_o;
  logic [3:0]  mem_b_en_o;
  logic [31:0] mem_rdata;

  mem_burst_master #(
    .NUM_WORDS (NW),
    .DATA_WIDTH(DW),
    .BYTE_WIDTH(8),
    .LATENCY   (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_write_i (cmd_write_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .wr_valid_i  (wr_valid_i),
    .wr_ready_o  (wr_ready_o),
    .wr_data_i   (wr_data_i),
    .wr_ben_i    (wr_ben_i),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .rd_data_o   (rd_data_o),
    .done_o      (done_o),
    .mem_req_o   (mem_req_o),
    .mem_w_en_o  (mem_w_en_o),
    .mem_addr_o  (mem_addr_o),
    .mem_w_data_o(mem_w_data_o),
    .mem_b_en_o  (mem_b_en_o),
    .mem_r_data_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: byte-enabled writes, read data registered one cycle after request.
  logic [31:0] mem [NW];
  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_req_o) begin
      if (mem_w_en_o) begin
        w = mem[mem_addr_o];
        for (int b = 0; b < 4; b++)
          if (mem_b_en_o[b]) w[b*8 +: 8] = mem_w_data_o[b*8 +: 8];
        mem[mem_addr_o] <= w;
      end else begin
        mem_rdata <= mem[mem_addr_o];
      end
    end
  end

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  ben;
  } req_t;

  req_t        exp_req [$];
  logic [31:0] exp_rd  [$];
  int          hs_cyc  [$];
  int          errors   = 0;
  int          checks   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sample outputs mid-cycle and run the scoreboard.
  task automatic sample();
    req_t e;
    @(negedge clk);
    cyc++;
    if (done_o) done_cnt++;
    if (mem_req_o) begin
      if (exp_req.size() == 0) chk("unexpected_mem_req", mem_req_o, 1'b0);
      else begin
        e = exp_req.pop_front();
        chk("mem_req", {mem_w_en_o, mem_addr_o, mem_w_data_o, mem_b_en_o}, e);
      end
    end else begin
      chk("idle_mem_bus", {mem_w_en_o, mem_addr_o, mem_w_data_o, mem_b_en_o}, '0);
    end
    if (rd_valid_o) begin
      if (exp_rd.size() == 0) chk("unexpected_rd_valid", rd_valid_o, 1'b0);
      else begin
        chk("rd_data", rd_data_o, exp_rd[0]);
        if (rd_ready_i) begin
          void'(exp_rd.pop_front());
          hs_cyc.push_back(cyc);
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready_o, 1'b1);
    chk({tag, "_ctrl"}, {wr_ready_o, rd_valid_o, done_o, mem_req_o, mem_w_en_o}, '0);
    chk({tag, "_rd_data"}, rd_data_o, '0);
    chk({tag, "_mem_bus"}, {mem_addr_o, mem_w_data_o, mem_b_en_o}, '0);
  endtask

  task automatic wr_burst(input logic [7:0] a, input int unsigned n, input logic [31:0] base);
    int unsigned d0 = done_cnt;
    logic [7:0]  ad = a;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = a; cmd_len_i = 9'(n);
    for (int unsigned i = 0; i < n; i++) begin
      exp_req.push_back(req_t'{we: 1'b1, addr: ad, data: base + i, ben: 4'hF});
      ad++;
    end
    sample(); chk("wr_cmd_ready", cmd_ready_o, 1'b1); advance();
    cmd_valid_i = 1'b0; wr_valid_i = 1'b1; wr_ben_i = 4'hF;
    for (int unsigned i = 0; i < n; i++) begin
      wr_data_i = base + i;
      sample();
      chk("wr_ready", wr_ready_o, 1'b1);
      chk("wr_beat_req", mem_req_o, 1'b1);
      chk("wr_no_early_done", done_o, 1'b0);
      advance();
    end
    wr_valid_i = 1'b0; wr_data_i = '0; wr_ben_i = '0;
    sample(); chk("wr_done_pulse", done_o, 1'b1); chk("wr_done_not_ready", cmd_ready_o, 1'b0); advance();
    sample();
    chk("wr_back_idle", cmd_ready_o, 1'b1);
    chk("wr_done_once", done_cnt - d0, 1);
    chk("wr_all_issued", exp_req.size(), 0);
    advance();
  endtask

  task automatic rd_burst(input logic [7:0] a, input int unsigned n, input logic [31:0] base,
                          input int unsigned stall_beat, input int unsigned stall_len,
                          input bit check_spacing);
    int unsigned d0 = done_cnt;
    int unsigned beats;
    int unsigned stalled = 0;
    logic [7:0]  ad = a;
    bit          seen = 1'b0;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = a; cmd_len_i = 9'(n);
    for (int unsigned i = 0; i < n; i++) begin
      exp_req.push_back(req_t'{we: 1'b0, addr: ad, data: '0, ben: '0});
      exp_rd.push_back(base + i);
      ad++;
    end
    hs_cyc.delete();
    sample(); chk("rd_cmd_ready", cmd_ready_o, 1'b1); advance();
    cmd_valid_i = 1'b0;
    for (int budget = 0; budget < 200 && !seen; budget++) begin
      beats = n - exp_rd.size();
      if (rd_valid_o && beats == stall_beat && stalled < stall_len) begin
        rd_ready_i = 1'b0;
        stalled++;
      end else begin
        rd_ready_i = 1'b1;
      end
      sample();
      if (!rd_ready_i) begin
        chk("stall_rd_valid", rd_valid_o, 1'b1);
        chk("stall_no_req", mem_req_o, 1'b0);
      end
      if (done_o) seen = 1'b1;
      advance();
    end
    rd_ready_i = 1'b0;
    chk("rd_done_seen", seen, 1'b1);
    chk("rd_stall_cycles", stalled, stall_len);
    chk("rd_done_once", done_cnt - d0, 1);
    chk("rd_all_data", exp_rd.size(), 0);
    chk("rd_all_req", exp_req.size(), 0);
    if (check_spacing)
      for (int i = 1; i < hs_cyc.size(); i++)
        chk("rd_spacing", hs_cyc[i] - hs_cyc[i-1], 3);
    sample(); chk("rd_back_idle", cmd_ready_o, 1'b1); advance();
  endtask

  initial begin
    int unsigned d0;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0;
    wr_valid_i = 1'b0; wr_data_i = '0; wr_ben_i = '0; rd_ready_i = 1'b0;
    advance();
    sample(); chk_reset_outputs("reset"); advance();
    rst_i = 1'b0;
    sample(); chk("idle_ready", cmd_ready_o, 1'b1); advance();

    // Write burst, then read it back unstalled.
    wr_burst(8'h10, 4, 32'hA0);
    rd_burst(8'h10, 4, 32'hA0, 99, 0, 1'b1);

    // Read with five-cycle consumer stall on the first word.
    rd_burst(8'h10, 2, 32'hA0, 0, 5, 1'b0);

    // Address wrap at the top of memory, then read across the wrap.
    wr_burst(8'hFE, 4, 32'hB0);
    rd_burst(8'hFE, 4, 32'hB0, 2, 3, 1'b0);

    // Zero-length command.
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 8'h33; cmd_len_i = '0;
    sample(); chk("zl_cmd_ready", cmd_ready_o, 1'b1); advance();
    cmd_valid_i = 1'b0;
    sample();
    chk("zl_done", done_o, 1'b1);
    chk("zl_no_req", mem_req_o, 1'b0);
    chk("zl_not_ready", cmd_ready_o, 1'b0);
    advance();
    sample(); chk("zl_ready_again", cmd_ready_o, 1'b1); chk("zl_done_clear", done_o, 1'b0); advance();

    // Reset while waiting on read data.
    d0 = done_cnt;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 8'h10; cmd_len_i = 9'd4;
    for (int unsigned i = 0; i < 4; i++) begin
      exp_req.push_back(req_t'{we: 1'b0, addr: 8'(8'h10 + i), data: '0, ben: '0});
      exp_rd.push_back(32'hA0 + i);
    end
    sample(); chk("rst_cmd_ready", cmd_ready_o, 1'b1); advance();
    cmd_valid_i = 1'b0; rd_ready_i = 1'b1;
    sample(); chk("rst_issue_req", mem_req_o, 1'b1); advance();
    rst_i = 1'b1;
    sample(); chk("rst_wait_no_req", mem_req_o, 1'b0); advance();
    rst_i = 1'b0;
    exp_req.delete();
    exp_rd.delete();
    sample(); chk_reset_outputs("post_rst"); advance();
    repeat (10) begin
      sample();
      advance();
    end
    chk("rst_no_done", done_cnt - d0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
